qop_mem_reader: RTL and testbench
=================================

Name: qop_mem_reader

Overview:
- Consumer side of the issued-instruction memory.
- The time controller writes 18-bit {opcode, angle} words into a 2048-entry dual-port RAM at sequential addresses. This block reads those words back in write order from the RAM read port.
- It splits each word into opcode/angle, optionally discards NOPs, and presents each remaining op to the pulse-generation stage over a valid/ready handshake.

Parameters:
- ADDR_W, 11, RAM address width; depth = 2**ADDR_W.
- DATA_W, 18, RAM word width: opcode[17:11], angle[10:0].
- NOP_OPCODE, 7'h00, opcode value treated as NOP.
- DROP_NOP, 1, 1 = NOP words are consumed but never presented on the output.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- wr_pulse  in  1  mirror of the time controller's memory write enable; one pulse per stored word.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_rd_en.
- op_valid  out  1  output op available.
- op_ready  in  1  downstream accepts the op.
- op_opcode  out  7  decoded opcode.
- op_angle  out  11  decoded angle.
- occupancy  out  ADDR_W+1  words written but not yet consumed.
- overflow  out  1  sticky: a write arrived while occupancy == 2**ADDR_W.
- issued_cnt  out  16  ops accepted downstream; wraps at 2**16.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, issued_cnt, overflow and all outputs go to 0.
  - FSM goes to IDLE.
  - Applies immediately, including mid-operation. Any in-flight read or presented op is discarded.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
  - occupancy = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - mem_rd_addr = rd_ptr[ADDR_W-1:0].
- Write tracking:
  - Each wr_pulse increments wr_ptr on the following edge.
  - A wr_pulse while occupancy == 2**ADDR_W sets overflow and does not increment wr_ptr.
  - overflow is cleared only by reset.
- FSM states: IDLE, READ, LATCH, PRESENT.
  - IDLE: if occupancy != 0, go to READ.
  - READ: mem_rd_en=1 for exactly this cycle, then go to LATCH.
  - LATCH: capture mem_rd_data into the op registers.
    - If DROP_NOP=1 and the captured opcode == NOP_OPCODE: rd_ptr++, go to IDLE.
    - Otherwise go to PRESENT.
  - PRESENT: op_valid=1; op_opcode and op_angle are held stable.
    - On op_valid && op_ready: rd_ptr++, issued_cnt++, go to IDLE.
- Handshake rules:
  - op_valid never deasserts without acceptance.
  - op_valid does not depend combinationally on op_ready.
  - Throughput is at most one op per 4 cycles; this is acceptable for the gate-rate stream.
- Latency: a wr_pulse at cycle N (FSM idle, ready held high) gives:
  - occupancy = 1 at N+1
  - READ at N+2
  - LATCH at N+3
  - op_valid=1 at N+4
- Simultaneous events:
  - A wr_pulse and a consume (rd_ptr++) in the same cycle leave occupancy unchanged.
  - At full occupancy with a consume in the same cycle, the write is accepted and overflow is not set.
- Wrap-around:
  - After address 2**ADDR_W-1 the read address returns to 0.
  - occupancy stays correct across the wrap through the MSB wrap bit.
- Output values outside PRESENT: op_opcode and op_angle hold their last captured values, and op_valid=0.

Decomposition:
- Shared package qc_pkg:
  - QC_ADDR_W = 11, QC_DATA_W = 18.
  - Opcode/angle field bounds: OPC_MSB=17, OPC_LSB=11, ANG_MSB=10, ANG_LSB=0.
  - QC_NOP_OPCODE.
  - Reader FSM enum typedef rd_state_t.
  - These constants are also used by the time controller.
- One sub-module, qc_ring_ptr: tracks wr/rd pointers, occupancy and overflow. It has inc_wr and inc_rd inputs and produces ptr/occupancy/overflow outputs.

Test Plan:
- Single word: RAM[0]=18'h0A0FF, one wr_pulse, op_ready=1 -> op_valid rises 4 cycles after the pulse with op_opcode=7'h14 and op_angle=11'h0FF; issued_cnt=1; occupancy returns to 0.
- Backpressure: 3 words written, op_ready=0 for 20 cycles -> op_valid stays high with the first op stable and occupancy=3; release -> ops emerge in addresses 0,1,2 order.
- NOP drop: words {NOP, 7'h05/angle 11'h123}, DROP_NOP=1 -> only opcode 7'h05/angle 11'h123 is presented; occupancy reaches 0; issued_cnt=1.
- Wrap/full: 2048 writes with op_ready=0 -> occupancy=2048, overflow=0; one more write -> overflow=1. Drain all -> read addresses go 0..2047, and a subsequent write at address 0 reads back correctly.
- Simultaneous: a wr_pulse coinciding with a handshake accept at occupancy=2048 -> occupancy stays 2048 and overflow stays 0.
- Reset mid-op: assert reset during PRESENT, asynchronously between clock edges -> op_valid, occupancy, mem_rd_en and issued_cnt go to 0 immediately; FSM is in IDLE after release.

Source files
------------

// File: rtl/qc_pkg.sv
// Shared constants and types for the issued-instruction memory path.
// Word layout, NOP opcode and reader FSM states (also used by the time controller).
package qc_pkg;

  localparam int QC_ADDR_W = 11;
  localparam int QC_DATA_W = 18;

  localparam int OPC_MSB = 17;
  localparam int OPC_LSB = 11;
  localparam int ANG_MSB = 10;
  localparam int ANG_LSB = 0;

  localparam logic [6:0] QC_NOP_OPCODE = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LATCH,
    PRESENT
  } rd_state_t;

endpackage

// File: rtl/qc_ring_ptr.sv
// Write/read pointer pair for the issued-instruction RAM with wrap bit.
// Ports: clk, reset (async low), inc_wr, inc_rd -> wr_ptr, rd_ptr, occupancy, overflow.
module qc_ring_ptr #(
  parameter int ADDR_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_wr,
  input  logic            inc_rd,
  output logic [ADDR_W:0] wr_ptr,
  output logic [ADDR_W:0] rd_ptr,
  output logic [ADDR_W:0] occupancy,
  output logic            overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic full;
  logic wr_ok;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == DEPTH);
  // A consume in the same cycle frees the slot the write needs.
  assign wr_ok     = inc_wr && (!full || inc_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (inc_rd)
        rd_ptr <= rd_ptr + 1'b1;
      if (inc_wr && full && !inc_rd)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/qop_mem_reader.sv
// Reads issued {opcode, angle} words back in write order and presents them downstream.
// Ports: clk, reset, wr_pulse, mem_rd_*, op_valid/op_ready/op_opcode/op_angle, occupancy, overflow, issued_cnt.
module qop_mem_reader
  import qc_pkg::*;
#(
  parameter int         ADDR_W     = QC_ADDR_W,
  parameter int         DATA_W     = QC_DATA_W,
  parameter logic [6:0] NOP_OPCODE = QC_NOP_OPCODE,
  parameter bit         DROP_NOP   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_pulse,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [6:0]        op_opcode,
  output logic [10:0]       op_angle,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow,
  output logic [15:0]       issued_cnt
);

  rd_state_t state;

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [6:0]      rd_opc;
  logic [10:0]     rd_ang;
  logic            drop;
  logic            accept;
  logic            inc_rd;

  assign rd_opc = mem_rd_data[OPC_MSB:OPC_LSB];
  assign rd_ang = mem_rd_data[ANG_MSB:ANG_LSB];
  assign drop   = DROP_NOP && (rd_opc == NOP_OPCODE);
  assign accept = (state == PRESENT) && op_valid && op_ready;
  assign inc_rd = accept || ((state == LATCH) && drop);

  assign mem_rd_addr = rd_ptr[ADDR_W-1:0];

  qc_ring_ptr #(
    .ADDR_W(ADDR_W)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc_wr   (wr_pulse),
    .inc_rd   (inc_rd),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .occupancy(occupancy),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_rd_en  <= 1'b0;
      op_valid   <= 1'b0;
      op_opcode  <= '0;
      op_angle   <= '0;
      issued_cnt <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (occupancy != '0) begin
            state     <= READ;
            mem_rd_en <= 1'b1;
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          op_opcode <= rd_opc;
          op_angle  <= rd_ang;
          if (drop) begin
            state <= IDLE;
          end else begin
            state    <= PRESENT;
            op_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (accept) begin
            op_valid   <= 1'b0;
            issued_cnt <= issued_cnt + 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

  // Keep the unused pointer visible to lint without exporting it.
  logic unused_wr;
  assign unused_wr = ^wr_ptr;

endmodule

// File: tb/tb_qop_mem_reader.sv
// Directed bench for qop_mem_reader with a RAM model and an in-order scoreboard.
// Stimulus runs linearly in one initial block; a negedge monitor checks reads and ops.
module tb_qop_mem_reader;
  import qc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_pulse = 1'b0;
  logic        mem_rd_en;
  logic [10:0] mem_rd_addr;
  logic [17:0] mem_rd_data = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [6:0]  op_opcode;
  logic [10:0] op_angle;
  logic [11:0] occupancy;
  logic        overflow;
  logic [15:0] issued_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [10:0] ang;
    logic [10:0] addr;
    bit          nop;
  } sb_t;

  sb_t sb[$];
  logic [17:0] ram [2048];
  logic [11:0] wa = '0;

  qop_mem_reader dut (
    .clk        (clk),
    .reset      (reset),
    .wr_pulse   (wr_pulse),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_opcode  (op_opcode),
    .op_angle   (op_angle),
    .occupancy  (occupancy),
    .overflow   (overflow),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en)
      mem_rd_data <= ram[mem_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [6:0] opc, input logic [10:0] ang);
    sb_t e;
    ram[wa[10:0]] = {opc, ang};
    e.opc  = opc;
    e.ang  = ang;
    e.addr = wa[10:0];
    e.nop  = (opc == 7'h00);
    sb.push_back(e);
    wa = wa + 1'b1;
    wr_pulse = 1'b1;
    tick();
    wr_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    sb.delete();
    wa = '0;
    tick();
  endtask

  task automatic wait_occ0(input int budget);
    int n;
    n = 0;
    while (occupancy != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(occupancy), 32'd0);
  endtask

  // Scoreboard monitor: read addresses follow write order, NOPs vanish,
  // every accepted op matches the oldest outstanding word.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL rd_unexpected observed=%0h expected=none", mem_rd_addr);
        end
        if (sb.size() != 0) begin
          chk("rd_addr", 32'(mem_rd_addr), 32'(sb[0].addr));
          if (sb[0].nop)
            void'(sb.pop_front());
        end
      end
      if (op_valid && op_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL op_unexpected observed=%0h expected=none", op_opcode);
        end
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("op_opcode", 32'(op_opcode), 32'(e.opc));
          chk("op_angle", 32'(op_angle), 32'(e.ang));
        end
      end
    end
  end

  initial begin
    logic [6:0]  o;
    logic [10:0] a;

    // reset state
    #3;
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    do_reset();

    // single word and latency
    op_ready = 1'b1;
    wr_word(7'h14, 11'h0FF);
    chk("lat_occ1", 32'(occupancy), 32'd1);
    tick();
    chk("lat_read", 32'(mem_rd_en), 32'd1);
    tick();
    chk("lat_latch", 32'(op_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(op_valid), 32'd1);
    chk("single_opc", 32'(op_opcode), 32'h14);
    chk("single_ang", 32'(op_angle), 32'h0FF);
    tick();
    chk("single_issued", 32'(issued_cnt), 32'd1);
    chk("single_occ0", 32'(occupancy), 32'd0);
    chk("single_vld0", 32'(op_valid), 32'd0);
    chk("hold_opc", 32'(op_opcode), 32'h14);

    // backpressure
    do_reset();
    op_ready = 1'b0;
    wr_word(7'h21, 11'h001);
    wr_word(7'h22, 11'h002);
    wr_word(7'h23, 11'h003);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(op_valid), 32'd1);
      chk("bp_opc", 32'(op_opcode), 32'h21);
      chk("bp_occ", 32'(occupancy), 32'd3);
      tick();
    end
    op_ready = 1'b1;
    wait_occ0(40);
    chk("bp_issued", 32'(issued_cnt), 32'd3);

    // NOP drop
    do_reset();
    op_ready = 1'b1;
    wr_word(7'h00, 11'h055);
    wr_word(7'h05, 11'h123);
    wait_occ0(40);
    tick();
    tick();
    chk("nop_issued", 32'(issued_cnt), 32'd1);
    chk("nop_sb_empty", 32'(sb.size()), 32'd0);

    // fill to full with downstream stalled
    do_reset();
    op_ready = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      o = 7'((i % 127) + 1);
      a = 11'(i) ^ 11'h5A5;
      wr_word(o, a);
    end
    chk("full_occ", 32'(occupancy), 32'd2048);
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_valid", 32'(op_valid), 32'd1);

    // write and accept together at full: slot freed, no overflow
    op_ready = 1'b1;
    wr_word(7'h3C, 11'h7E1);
    op_ready = 1'b0;
    chk("sim_occ", 32'(occupancy), 32'd2048);
    chk("sim_ovf", 32'(overflow), 32'd0);
    chk("sim_issued", 32'(issued_cnt), 32'd1);
    repeat (4) tick();
    chk("sim_valid", 32'(op_valid), 32'd1);

    // write at full without a consume is lost and sticky-flagged
    wr_pulse = 1'b1;
    tick();
    wr_pulse = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_occ", 32'(occupancy), 32'd2048);

    // drain across the address wrap
    op_ready = 1'b1;
    wait_occ0(12000);
    tick();
    chk("wrap_issued", 32'(issued_cnt), 32'd2049);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // asynchronous reset in the middle of PRESENT
    op_ready = 1'b0;
    wr_word(7'h11, 11'h222);
    repeat (5) tick();
    chk("pre_rst_valid", 32'(op_valid), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(op_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_issued", 32'(issued_cnt), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    sb.delete();
    wa = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("arst_idle", 32'(dut.state), 32'(IDLE));
    repeat (4) tick();
    chk("arst_quiet", 32'(op_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
